// File: rtl/rte_eink_pkg.sv
// Shared types and pad-frame bit assignments for the segmented e-ink driver.
package rte_eink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_B = 2'd1,
        DRIVE_W = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int UPDATE  = 0;
    localparam int COM     = 1;
    localparam int BUSY    = 2;
    localparam int DONE    = 3;
    localparam int REPS_LO = 4;
    localparam int LEN_LO  = 6;

    localparam logic [7:0] UIO_OE = 8'b0000_1110;

endpackage

// File: rtl/eink_phase_timer.sv
// Phase timer: reloads on every phase entry and flags the last cycle of a phase.
module eink_phase_timer #(
    parameter int PRESCALE_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [1:0] i_len_sel,
    input  logic       i_en,
    output logic       o_expired
);
    localparam int CW = PRESCALE_W + 2;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_ld;

    // ((len_sel+1) << PRESCALE_W) - 1 without an adder.
    assign w_ld      = {i_len_sel, {PRESCALE_W{1'b1}}};
    assign o_expired = i_en && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_ld;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/rte_eink_driver.sv
// Segmented e-ink direct-drive controller: DC-balanced B/W phase pairs, then a
// settle phase at 0 V. Outputs are registered from the next state so they only move on phase edges.
module rte_eink_driver
    import rte_eink_pkg::*;
#(
    parameter int PRESCALE_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_t     r_state;
    state_t     w_nxt;
    logic       r_prev;
    logic [7:0] r_pat;
    logic [1:0] r_reps;
    logic [1:0] r_len;
    logic [1:0] r_rep;
    logic [7:0] r_uo;
    logic       r_com;
    logic       r_busy;
    logic       r_done;

    logic       w_start;
    logic       w_take;
    logic       w_exp;
    logic       w_load;
    logic [1:0] w_len_ld;
    logic [7:0] w_pat;
    logic       w_unused;

    assign w_start  = uio_in[UPDATE] & ~r_prev;
    assign w_take   = ena && (r_state == IDLE) && w_start;
    assign w_load   = (w_nxt != r_state);
    // The first phase is loaded on the same edge the config is latched.
    assign w_len_ld = (r_state == IDLE) ? uio_in[LEN_LO +: 2] : r_len;
    assign w_pat    = (r_state == IDLE) ? ui_in : r_pat;
    assign w_unused = ^uio_in[3:1];

    eink_phase_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_len_sel (w_len_ld),
        .i_en      (r_state != IDLE),
        .o_expired (w_exp)
    );

    always_comb begin
        w_nxt = r_state;
        if (!ena) begin
            w_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) w_nxt = DRIVE_B;
                DRIVE_B: if (w_exp)   w_nxt = DRIVE_W;
                DRIVE_W: if (w_exp)   w_nxt = (r_rep == r_reps) ? SETTLE : DRIVE_B;
                SETTLE:  if (w_exp)   w_nxt = IDLE;
                default:              w_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= 1'b1;
            r_pat   <= '0;
            r_reps  <= '0;
            r_len   <= '0;
            r_rep   <= '0;
            r_uo    <= '0;
            r_com   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_prev  <= uio_in[UPDATE];
            r_state <= w_nxt;
            if (w_take) begin
                r_pat  <= ui_in;
                r_reps <= uio_in[REPS_LO +: 2];
                r_len  <= uio_in[LEN_LO +: 2];
                r_rep  <= '0;
            end else if (ena && r_state == DRIVE_W && w_exp && r_rep != r_reps) begin
                r_rep <= r_rep + 2'd1;
            end
            r_uo   <= (w_nxt == DRIVE_B || w_nxt == DRIVE_W) ? w_pat : 8'h00;
            r_com  <= (w_nxt == DRIVE_W);
            r_busy <= (w_nxt != IDLE);
            r_done <= ena && (r_state == SETTLE) && w_exp;
        end
    end

    always_comb begin
        uio_out       = 8'h00;
        uio_out[COM]  = r_com;
        uio_out[BUSY] = r_busy;
        uio_out[DONE] = r_done;
    end

    assign uo_out = r_uo;
    assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_rte_eink_driver.sv
// Directed bench for rte_eink_driver with PRESCALE_W=2 (phase = (len+1)*4 clocks).
module tb_rte_eink_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    rte_eink_driver #(.PRESCALE_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ui;
        logic [1:0] reps;
        logic [1:0] len;
        int         busy_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise UPDATE with the given config; returns positioned at the negedge of cycle t+1.
    task automatic strobe(input logic [7:0] ui, input logic [1:0] reps, input logic [1:0] len);
        ui_in  = ui;
        uio_in = {len, reps, 3'b000, 1'b1};
        tick();
        uio_in[0] = 1'b0;
    endtask

    task automatic run_update(input vec_t v, input string name);
        int L, ph, nph;
        logic [7:0] exp_uo;
        logic       exp_com;
        L   = (int'(v.len) + 1) * 4;
        nph = 2 * (int'(v.reps) + 1);
        strobe(v.ui, v.reps, v.len);
        for (int k = 1; k <= v.busy_cycles; k++) begin
            ph      = (k - 1) / L;
            exp_uo  = (ph < nph) ? v.ui : 8'h00;
            exp_com = (ph < nph) && (ph % 2 == 1);
            chk({name, " uo"},   uo_out,     exp_uo);
            chk({name, " com"},  uio_out[1], exp_com);
            chk({name, " busy"}, uio_out[2], 1);
            chk({name, " done"}, uio_out[3], 0);
            if (k == 1) chk({name, " spare bits"}, uio_out & 8'hF1, 0);
            tick();
        end
        chk({name, " end busy"}, uio_out[2], 0);
        chk({name, " end done"}, uio_out[3], 1);
        chk({name, " end uo"},   uo_out, 0);
        tick();
        chk({name, " done width"}, uio_out[3], 0);
    endtask

    initial begin
        int dones;
        vecs[0] = '{8'hA5, 2'd0, 2'd0, 12};
        vecs[1] = '{8'h3C, 2'd1, 2'd3, 80};
        vecs[2] = '{8'hFF, 2'd3, 2'd0, 36};
        vecs[3] = '{8'h00, 2'd2, 2'd1, 56};
        vecs[4] = '{8'h81, 2'd0, 2'd2, 36};

        // Reset with UPDATE held high through release.
        rst = 1'b1; ena = 1'b1; ui_in = 8'h5A; uio_in = 8'h01;
        tick(); tick();
        chk("reset uo", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'h0E);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("held strobe busy", uio_out[2], 0);
        chk("held strobe uo", uo_out, 8'h00);
        uio_in = 8'h00;
        tick();

        foreach (vecs[i]) begin
            run_update(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Second strobe and pattern change during DRIVE_W are ignored.
        strobe(8'h3C, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        ui_in = 8'hFF; uio_in[0] = 1'b1;
        tick();
        chk("restrobe uo", uo_out, 8'h3C);
        chk("restrobe com", uio_out[1], 1);
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (uio_out[3]) dones++;
            tick();
        end
        chk("restrobe done count", dones, 1);
        chk("restrobe idle busy", uio_out[2], 0);
        uio_in = 8'h00;
        tick();

        // Reset during DRIVE_W.
        strobe(8'hA5, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset com", uio_out[1], 1);
        rst = 1'b1;
        tick();
        chk("midrst uo", uo_out, 8'h00);
        chk("midrst uio_out", uio_out, 8'h00);
        rst = 1'b0;
        tick();
        run_update(vecs[0], "post-reset");
        tick();

        // ena dropped during DRIVE_B, strobes ignored while disabled.
        strobe(8'h66, 2'd1, 2'd0);
        tick();
        chk("pre-abort uo", uo_out, 8'h66);
        ena = 1'b0;
        tick();
        chk("abort uo", uo_out, 8'h00);
        chk("abort uio_out", uio_out, 8'h00);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            uio_in[0] = (i % 2 == 0);
            tick();
            if (uio_out[3] || uio_out[2]) dones++;
        end
        uio_in[0] = 1'b0;
        tick();
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (uio_out[3] || uio_out[2]) dones++;
        end
        chk("disabled activity", dones, 0);
        run_update(vecs[4], "after-ena");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
